gbuff_stream_reader: RTL

//  Read-side initiator for the 4-bank global buffer. On start it walks a strided

---
 rtl/gbuff_stream_reader_pkg.sv | 15 +
 rtl/gbuff_stream_reader_if.sv | 39 +++
 rtl/gbuff_rd_fifo.sv | 40 ++++
 rtl/gbuff_stream_reader.sv | 112 +++++++++++
 4 files changed

// File: rtl/gbuff_stream_reader_pkg.sv
// Shared types and constants for the global-buffer stream reader.
package gbuff_stream_reader_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Capture FIFO depth; the issue throttle keeps occupancy at or below this
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/gbuff_stream_reader_if.sv
// Control, global-buffer and output-stream signals of the stream reader.
interface gbuff_stream_reader_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 9
);
  // transfer control
  logic                   start;
  logic [ADDR_BITS-1:0]   base_addr;
  logic [ADDR_BITS-1:0]   stride;
  logic [LEN_BITS-1:0]    length;
  logic                   busy;
  logic                   done;
  // global buffer side
  logic                   gb_wr_en;
  logic                   gb_batch_mode;
  logic [ADDR_BITS+1:0]   gb_index;
  logic [4*DATA_BITS-1:0] gb_data_in;
  logic [4*DATA_BITS-1:0] gb_data_out;
  // output stream
  logic                   m_valid;
  logic                   m_ready;
  logic [4*DATA_BITS-1:0] m_data;
  logic                   m_last;

  // reader side
  modport master (
    input  start, base_addr, stride, length, gb_data_out, m_ready,
    output busy, done, gb_wr_en, gb_batch_mode, gb_index, gb_data_in,
           m_valid, m_data, m_last
  );

  // host / buffer / downstream side
  modport slave (
    output start, base_addr, stride, length, gb_data_out, m_ready,
    input  busy, done, gb_wr_en, gb_batch_mode, gb_index, gb_data_in,
           m_valid, m_data, m_last
  );
endinterface

// File: rtl/gbuff_rd_fifo.sv
// Two-entry capture FIFO absorbing read data returned after the buffer latency.
module gbuff_rd_fifo
  import gbuff_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // Storage write; data is not reset, only pointers and count qualify it
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking; push and pop in one cycle keep count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/gbuff_stream_reader.sv
// Strided batch-mode reader for the 4-bank global buffer, streaming the
// returned words out over valid/ready.
module gbuff_stream_reader
  import gbuff_stream_reader_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 9
) (
  input logic                 clk,
  input logic                 rst,
  gbuff_stream_reader_if.master bus
);
  localparam int WORD_W = 4 * DATA_BITS;

  state_e                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pending;
  logic [ADDR_BITS-1:0]   r_rd_addr;
  logic [ADDR_BITS-1:0]   r_stride;
  logic [LEN_BITS-1:0]    r_issue_left;
  logic [LEN_BITS-1:0]    r_beat_left;
  logic [ADDR_BITS+1:0]   r_gb_index;

  logic [WORD_W-1:0]      w_head;
  logic [1:0]             w_count;
  logic                   w_valid;
  logic                   w_pop;
  logic [2:0]             w_occ;
  logic                   w_issue;

  assign w_valid = (w_count != 2'd0);
  assign w_pop   = w_valid & bus.m_ready;
  // Occupancy once this cycle's pop and the in-flight read are accounted for
  assign w_occ   = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_pending};
  assign w_issue = (r_state == ST_RUN) && (r_issue_left != '0) &&
                   (w_occ < 3'(FIFO_DEPTH));

  gbuff_rd_fifo #(.WIDTH(WORD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pending),
    .i_pop   (w_pop),
    .i_data  (bus.gb_data_out),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Sequencing FSM with address generator and issue/beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pending    <= 1'b0;
      r_rd_addr    <= '0;
      r_stride     <= '0;
      r_issue_left <= '0;
      r_beat_left  <= '0;
      r_gb_index   <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_gb_index   <= {2'b00, r_rd_addr};
        r_rd_addr    <= r_rd_addr + r_stride;
        r_issue_left <= r_issue_left - LEN_BITS'(1);
      end
      if (w_pop) r_beat_left <= r_beat_left - LEN_BITS'(1);

      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b1;
            r_rd_addr    <= bus.base_addr;
            r_stride     <= bus.stride;
            r_issue_left <= bus.length;
            r_beat_left  <= bus.length;
          end
        end
        ST_RUN: begin
          if (r_issue_left == '0) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Leave as soon as the final beat handshakes (or none remain)
          if ((r_beat_left == '0) || ((r_beat_left == LEN_BITS'(1)) && w_pop)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.gb_wr_en      = 1'b0;
  assign bus.gb_batch_mode = 1'b1;
  assign bus.gb_data_in    = '0;
  assign bus.gb_index      = w_issue ? {2'b00, r_rd_addr} : r_gb_index;
  assign bus.m_valid       = w_valid;
  assign bus.m_data        = w_valid ? w_head : '0;
  assign bus.m_last        = w_valid && (r_beat_left == LEN_BITS'(1));
endmodule
